mem_copy_dma: RTL and testbench

Bus initiator that copies a block of 32-bit words from one region of the 1 KB byte-addressed data memory to another. It drives the memory's MemRead/MemWrite/addr/wd pins and consumes its combinational rd. It sits beside the datapath as the master for block moves, so that the CPU does not loop over lw/sw pairs.

---
 rtl/mem_copy_dma_if.sv | 18 +
 rtl/mem_copy_dma.sv | 123 ++++++++++++
 tb/tb_mem_copy_dma.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: memory-side bus between the block-copy initiator and the
// 1 KB data memory.
//   MemRead  - read enable; rd is valid combinationally in the same cycle
//   MemWrite - write enable; memory writes on the posedge where it is high
//   addr     - byte address (word aligned)
//   wd       - write data, little-endian (wd[7:0] lands at addr)
//   rd       - read data returned by the memory
// Modports: master = the DMA, slave = the memory.
interface mem_copy_dma_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output MemRead, output MemWrite, output addr, output wd, input rd);
  modport slave  (input MemRead, input MemWrite, input addr, input wd, output rd);
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: copies word_count 32-bit words from src to dst inside a
// MEM_BYTES byte-addressed memory, one read/write pair per word, ascending.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   i_start           - request pulse, only honoured in IDLE
//   i_src_addr        - source byte address (must be word aligned)
//   i_dst_addr        - destination byte address (must be word aligned)
//   i_word_count      - number of words to copy
//   o_busy            - high while reading/writing
//   o_done            - one-cycle pulse at end of transfer (ok or fault)
//   o_error           - sticky fault flag, cleared on next accepted start
//   o_words_done      - words written in the current/last transfer
//   bus (master)      - memory strobes, address, write/read data
module mem_copy_dma #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [CNT_W-1:0] i_word_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_words_done,
  mem_copy_dma_if.master   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_src_ptr, r_dst_ptr, r_data;
  logic [CNT_W-1:0] r_remaining, r_words_done;
  logic             r_error;

  // Range check in 34 bits so a large count cannot wrap past the limit.
  logic [33:0] w_byte_len, w_src_end, w_dst_end;
  logic        w_misaligned, w_oob, w_fault, w_accept;

  assign w_byte_len   = 34'(i_word_count) << 2;
  assign w_src_end    = {2'b00, i_src_addr} + w_byte_len;
  assign w_dst_end    = {2'b00, i_dst_addr} + w_byte_len;
  assign w_misaligned = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00);
  assign w_oob        = (w_src_end > 34'(MEM_BYTES)) || (w_dst_end > 34'(MEM_BYTES));
  assign w_fault      = w_misaligned || w_oob;
  assign w_accept     = (r_state == IDLE) && i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_fault)                 w_state_nxt = DONE;
          else if (i_word_count == '0) w_state_nxt = DONE;
          else                         w_state_nxt = READ;
        end
      end
      READ:    w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (r_remaining == CNT_W'(1)) ? DONE : READ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs come only from registered state, never from start or rd.
  always_comb begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = '0;
    bus.wd       = '0;
    case (r_state)
      READ: begin
        bus.MemRead = 1'b1;
        bus.addr    = r_src_ptr;
      end
      WRITE: begin
        bus.MemWrite = 1'b1;
        bus.addr     = r_dst_ptr;
        bus.wd       = r_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_data       <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src_ptr    <= i_src_addr;
        r_dst_ptr    <= i_dst_addr;
        r_remaining  <= i_word_count;
        r_words_done <= '0;
        r_error      <= w_fault;
      end
      if (r_state == READ) r_data <= bus.rd;
      if (r_state == WRITE) begin
        r_src_ptr    <= r_src_ptr + 32'd4;
        r_dst_ptr    <= r_dst_ptr + 32'd4;
        r_remaining  <= r_remaining - CNT_W'(1);
        r_words_done <= r_words_done + CNT_W'(1);
      end
    end
  end

  assign o_busy       = (r_state == READ) || (r_state == WRITE);
  assign o_done       = (r_state == DONE);
  assign o_error      = r_error;
  assign o_words_done = r_words_done;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: table-driven directed transfers, hand-written corner
// sequences (ignored start, reset mid-copy, overlapping copy) and random
// transfers checked against a word-array reference model of the copy.
module tb_mem_copy_dma;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, error;
  logic [CNT_W-1:0] words_done;

  mem_copy_dma_if bus();

  mem_copy_dma #(.MEM_BYTES(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_word_count(word_count),
    .o_busy(busy), .o_done(done), .o_error(error), .o_words_done(words_done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge.
  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  assign bus.rd = mem[bus.addr[9:2]];
  always @(posedge clk) if (bus.MemWrite) mem[bus.addr[9:2]] <= bus.wd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s mem[word %0d]: got %0h expected %0h", name, bad, mem[bad], model_mem[bad]);
    end
  endtask

  // Reference: spec-level decision plus a plain ascending word copy.
  task automatic model_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            output logic err, output int exp_done, output int exp_words);
    longint se, de;
    se = longint'(s) + 4 * n;
    de = longint'(d) + 4 * n;
    err = (s[1:0] != 0) || (d[1:0] != 0) || (se > 1024) || (de > 1024);
    if (err || n == 0) begin
      exp_done = 1; exp_words = 0;
    end else begin
      for (int i = 0; i < n; i++) model_mem[d/4 + i] = model_mem[s/4 + i];
      exp_done = 2 * n + 1; exp_words = n;
    end
  endtask

  // Run one transfer and check timing, strobes, status and memory.
  task automatic do_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                         input int n, input logic exp_err, input int exp_done, input int exp_words);
    int done_cyc, pulses, busy_cyc, rd_cyc, wr_cyc, both;
    done_cyc = 0; pulses = 0; busy_cyc = 0; rd_cyc = 0; wr_cyc = 0; both = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = CNT_W'(n); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (bus.MemRead) rd_cyc++;
      if (bus.MemWrite) wr_cyc++;
      if (bus.MemRead && bus.MemWrite) both++;
      if (done) begin pulses++; if (done_cyc == 0) done_cyc = c; end
      if (done_cyc != 0 && c >= done_cyc + 2) break;
    end
    check({name, " done_cycle"}, done_cyc, exp_done);
    check({name, " done_pulses"}, pulses, 1);
    check({name, " busy_cycles"}, busy_cyc, 2 * exp_words);
    check({name, " reads"}, rd_cyc, exp_words);
    check({name, " writes"}, wr_cyc, exp_words);
    check({name, " rd_wr_overlap"}, both, 0);
    check({name, " error"}, error, exp_err);
    check({name, " words_done"}, words_done, exp_words);
    check({name, " idle_addr"}, bus.addr, 0);
    check({name, " idle_wd"}, bus.wd, 0);
    check_mem(name);
  endtask

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          cnt;
    logic        exp_err;
    int          exp_done;
    int          exp_words;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic e; int ed, ew;
    logic [31:0] rs, rdst;
    int rn, done_cyc;

    vecs[0] = '{"copy4",      32'd0,    32'd256, 4, 1'b0, 9, 4};
    vecs[1] = '{"zero_cnt",   32'd0,    32'd0,   0, 1'b0, 1, 0};
    vecs[2] = '{"mis_src",    32'd2,    32'd100, 1, 1'b1, 1, 0};
    vecs[3] = '{"after_err",  32'd0,    32'd8,   1, 1'b0, 3, 1};
    vecs[4] = '{"oob_src",    32'd1016, 32'd0,   3, 1'b1, 1, 0};
    vecs[5] = '{"edge_src",   32'd1016, 32'd0,   2, 1'b0, 5, 2};
    vecs[6] = '{"top_word",   32'd1020, 32'd40,  1, 1'b0, 3, 1};
    vecs[7] = '{"mis_dst",    32'd0,    32'd6,   1, 1'b1, 1, 0};

    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; model_mem[i] = mem[i]; end
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) model_mem[i] = mem[i];

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst words_done", words_done, 0);
    check("rst MemRead", bus.MemRead, 0);
    check("rst MemWrite", bus.MemWrite, 0);
    check("rst addr", bus.addr, 0);
    check("rst wd", bus.wd, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      model_xfer(vecs[v].src, vecs[v].dst, vecs[v].cnt, e, ed, ew);
      do_xfer(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].cnt,
              vecs[v].exp_err, vecs[v].exp_done, vecs[v].exp_words);
    end
    check("copy4 dst word0", mem[64], 32'h11111111);
    check("copy4 dst word3", mem[67], 32'h44444444);

    // Overlapping ascending copy: A B C D -> A A A A
    mem[0] = 32'hAAAA0000; mem[1] = 32'hBBBB0001; mem[2] = 32'hCCCC0002; mem[3] = 32'hDDDD0003;
    for (int i = 0; i < 4; i++) model_mem[i] = mem[i];
    model_xfer(32'd0, 32'd4, 3, e, ed, ew);
    do_xfer("overlap", 32'd0, 32'd4, 3, 1'b0, 7, 3);
    for (int i = 0; i < 4; i++) check("overlap word", mem[i], 32'hAAAA0000);

    // Second start during a busy copy is ignored
    model_xfer(32'd0, 32'd512, 4, e, ed, ew);
    @(negedge clk);
    src_addr = 32'd0; dst_addr = 32'd512; word_count = 16'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = c;
      if (c == 3) begin src_addr = 32'd64; dst_addr = 32'd768; word_count = 16'd1; start = 1'b1; end
      else start = 1'b0;
      if (done_cyc != 0) break;
    end
    check("ignore done_cycle", done_cyc, 9);
    check("ignore words_done", words_done, 4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ignore no_requeue busy", busy, 0);
    end
    check_mem("ignore");

    // Reset during the second WRITE cycle: only word 0 lands
    model_mem[150] = model_mem[0];
    @(negedge clk);
    src_addr = 32'd0; dst_addr = 32'd600; word_count = 16'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    check("midrst in_write", bus.MemWrite, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst error", error, 0);
    check("midrst words_done", words_done, 0);
    check("midrst MemRead", bus.MemRead, 0);
    check("midrst MemWrite", bus.MemWrite, 0);
    check("midrst addr", bus.addr, 0);
    check("midrst wd", bus.wd, 0);
    @(negedge clk); rst_n = 1'b1;
    check_mem("midrst");
    model_xfer(32'd4, 32'd700, 1, e, ed, ew);
    do_xfer("post_rst", 32'd4, 32'd700, 1, e, ed, ew);

    // Random transfers against the reference model
    for (int t = 0; t < 40; t++) begin
      rn   = $urandom_range(0, 8);
      rs   = 32'($urandom_range(0, 255)) * 4;
      rdst = 32'($urandom_range(0, 255)) * 4;
      case ($urandom_range(0, 9))
        0: rs   = rs | 32'($urandom_range(1, 3));
        1: rdst = rdst | 32'($urandom_range(1, 3));
        2: rs   = 32'd1024 - 32'(4 * rn);
        3: rdst = rs + 32'd4;
        default: ;
      endcase
      model_xfer(rs, rdst, rn, e, ed, ew);
      do_xfer("rand", rs, rdst, rn, e, ed, ew);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
